lane_stream_reg: RTL

Parameterised lane register bank for the matrix-multiply datapath. It holds LANES words of LANE_W bits each, loaded in parallel under a per-lane mask, and exposes them as a flat parallel output. On command it also streams the lanes out one word per beat over a valid/ready handshake, so a row or column can feed a serial MAC stage while the parallel view stays stable.

---
 rtl/lane_stream_reg.sv | 115 +++++++++++
 1 files changed

// File: rtl/lane_stream_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : lane_stream_reg
// Description : Masked parallel-load lane register bank with a parallel view
//               and a valid/ready serial stream of lanes 0..LANES-1.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module lane_stream_reg #(
   parameter int LANE_W = 8,
   parameter int LANES  = 12,
   parameter int IDX_W  = 4
) (
   input  logic                    CLK,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    ld,
   input  logic [LANES-1:0]        ld_mask,
   input  logic [LANES*LANE_W-1:0] din,
   output logic [LANES*LANE_W-1:0] dout,
   input  logic                    start,
   output logic                    s_valid,
   input  logic                    s_ready,
   output logic [LANE_W-1:0]       s_data,
   output logic                    s_last,
   output logic                    busy,
   output logic                    done
);

   localparam logic [0:0]       c_idle   = 1'b0;
   localparam logic [0:0]       c_stream = 1'b1;
   localparam logic [IDX_W-1:0] c_last   = IDX_W'(LANES - 1);

   logic [0:0]       r_state, w_state_nxt;
   logic [IDX_W-1:0] r_idx,   w_idx_nxt;
   logic             r_done,  w_done_nxt;
   logic             w_xfer;
   logic             w_load;
   logic [LANE_W-1:0] r_lane [LANES];

   // Lanes only accept loads while idle so the streamed row stays coherent.
   assign w_xfer = (r_state == c_stream) && s_ready;
   assign w_load = ld && !clr && (r_state == c_idle);

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
               r_lane[i] <= '0;
            end else if (clr) begin
               r_lane[i] <= '0;
            end else if (w_load && ld_mask[i]) begin
               r_lane[i] <= din[i*LANE_W +: LANE_W];
            end
         end
         assign dout[i*LANE_W +: LANE_W] = r_lane[i];
      end
   endgenerate

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
         r_idx   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      if (clr) begin
         w_state_nxt = c_idle;
         w_idx_nxt   = '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (start) begin
                  w_state_nxt = c_stream;
                  w_idx_nxt   = '0;
               end
            end
            c_stream: begin
               if (w_xfer) begin
                  if (r_idx == c_last) begin
                     w_state_nxt = c_idle;
                     w_idx_nxt   = '0;
                     w_done_nxt  = 1'b1;
                  end else begin
                     w_idx_nxt = r_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = c_idle;
               w_idx_nxt   = '0;
            end
         endcase
      end
   end

   // idx is held at 0 while idle, so s_data shows lane 0 there.
   always_comb begin
      busy    = (r_state == c_stream);
      s_valid = (r_state == c_stream);
      s_last  = (r_state == c_stream) && (r_idx == c_last);
      s_data  = r_lane[r_idx];
      done    = r_done;
   end

endmodule
`default_nettype wire
